lif_spike_generator: RTL and testbench
======================================

// Module: lif_spike_generator
// PURPOSE
//  Leaky integrate-and-fire neuron that turns the 8-bit signed input current into output spikes.
//  Sits downstream of the input-current stage and closes the loop: its spike bit feeds the
//  input_spikes bus of the next layer. One neuron per instance, updated once per enabled timestep.
// PARAMETERS
//  VTH        8'sd64  signed firing threshold (fire when next potential >= VTH)
//  V_RESET    8'sd0   signed potential loaded after a spike
//  LEAK_SHIFT 3       leak = v >>> LEAK_SHIFT (arithmetic), subtracted each enabled step
//  REFRAC     2       refractory length in enabled steps (0 = none)
// PORTS
//  clk                in   1   system clock, rising edge
//  reset              in   1   asynchronous, active-high; clears all state
//  enable             in   1   timestep strobe; state advances only when high
//  input_current      in   8   signed current for this timestep
//  spike              out  1   one-cycle registered spike pulse
//  membrane_potential out  8   signed current potential v
//  refractory         out  1   high while refractory counter != 0
//  spike_count        out  16  saturating count of emitted spikes
// BEHAVIOUR
//  - Reset (async, any time, including mid-refractory): v=0, spike=0, refractory=0, count=0,
//    spike_count=0, state=INTEGRATE. Outputs are all registers.
//  - FSM states: INTEGRATE, REFRACTORY. Transitions are evaluated only in enable cycles.
//  - enable=0: v, counter, spike_count hold; spike=0 on the next edge.
//  - INTEGRATE & enable: sum = v - (v>>>LEAK_SHIFT) + input_current, computed in 10-bit signed.
//    vn = sum saturated to [-128,127].
//    * vn >= VTH: spike=1 on the next edge, v=V_RESET, spike_count++ (holds at 16'hFFFF).
//      If REFRAC>0: count=REFRAC and state goes to REFRACTORY; else state stays INTEGRATE.
//    * otherwise: v=vn, spike=0.
//  - REFRACTORY & enable: input_current is ignored, v is held at V_RESET, spike=0, count--.
//    When count reaches 0, state goes to INTEGRATE, so the next enabled step integrates normally.
//  - Latency: spike asserts exactly 1 clock after the enable cycle that crossed the threshold,
//    for 1 clock only. Back-to-back enables with REFRAC=0 can produce spikes on consecutive cycles.
//  - Threshold compare uses the saturated vn. A vn of exactly VTH fires.
// CONFIGURATION
//  SPIKE_REFRACTORY_EN defined: refractory counter, REFRACTORY state and behaviour as above.
//  SPIKE_REFRACTORY_EN undefined: no counter, REFRAC is ignored, refractory is tied 0, and the
//    neuron always returns to INTEGRATE immediately after firing.
// TESTING (VTH=64, V_RESET=0, LEAK_SHIFT=3, REFRAC=2, SPIKE_REFRACTORY_EN defined)
//  1 Assert reset mid-run -> all outputs 0 immediately, without waiting for a clock edge.
//  2 input_current=20, enable every cycle -> v: 20,38,54, then fires on the 4th step (sum 68);
//    spike high 1 cycle; v=0; spike_count=1.
//  3 One step with current=100 -> spike; the next 2 enabled steps with current=100 produce
//    no spike, refractory=1 and v=0; the 4th step spikes again.
//  4 current=-128 repeated -> v=-128, then sum=-240 saturates to -128; no spike and no wrap
//    to positive.
//  5 v=54, enable low for 5 cycles with current=127 -> v stays 54 and spike stays 0.
//  6 Reset asserted during REFRACTORY -> refractory=0 at once; the first step after release
//    integrates normally. Also rebuild without SPIKE_REFRACTORY_EN: re-run 3 -> spikes on
//    every step and refractory stays 0.

Source files
------------

// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: integrates signed input current and emits one-cycle spikes.
// Optional refractory period is enabled by defining SPIKE_REFRACTORY_EN.
module lif_spike_generator #(
    parameter logic signed [7:0] VTH        = 8'sd64,
    parameter logic signed [7:0] V_RESET    = 8'sd0,
    parameter int                LEAK_SHIFT = 3,
    parameter int                REFRAC     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [7:0] input_current,
    output logic              spike,
    output logic signed [7:0] membrane_potential,
    output logic              refractory,
    output logic [15:0]       spike_count
);

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    state_t            state, state_nxt;
    logic signed [9:0] v_ext, cur_ext, sum;
    logic signed [7:0] vn, v_nxt;
    logic              spike_nxt;
    logic [15:0]       count_nxt;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        if (x > 10'sd127)
            return 8'sh7F;
        else if (x < -10'sd128)
            return 8'sh80;
        else
            return x[7:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign v_ext   = {{2{membrane_potential[7]}}, membrane_potential};
    assign cur_ext = {{2{input_current[7]}}, input_current};
    assign sum     = v_ext - (v_ext >>> LEAK_SHIFT) + cur_ext;
    assign vn      = sat8(sum);

`ifdef SPIKE_REFRACTORY_EN
    logic [7:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        v_nxt     = membrane_potential;
        spike_nxt = 1'b0;
        count_nxt = spike_count;
        cnt_nxt   = cnt;
        if (enable) begin
            case (state)
                INTEGRATE: begin
                    if (vn >= VTH) begin
                        spike_nxt = 1'b1;
                        v_nxt     = V_RESET;
                        count_nxt = sat_inc16(spike_count);
                        if (REFRAC > 0) begin
                            cnt_nxt   = 8'(REFRAC);
                            state_nxt = REFRACTORY;
                        end
                    end else begin
                        v_nxt = vn;
                    end
                end
                REFRACTORY: begin
                    // Input is ignored while refractory; the potential is pinned at V_RESET.
                    v_nxt   = V_RESET;
                    cnt_nxt = cnt - 8'd1;
                    if (cnt_nxt == 8'd0)
                        state_nxt = INTEGRATE;
                end
                default: state_nxt = INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 8'd0;
            refractory <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            refractory <= (cnt_nxt != 8'd0);
        end
    end
`else
    always_comb begin
        state_nxt = INTEGRATE;
        v_nxt     = membrane_potential;
        spike_nxt = 1'b0;
        count_nxt = spike_count;
        if (enable && state == INTEGRATE) begin
            if (vn >= VTH) begin
                spike_nxt = 1'b1;
                v_nxt     = V_RESET;
                count_nxt = sat_inc16(spike_count);
            end else begin
                v_nxt = vn;
            end
        end
    end

    assign refractory = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= INTEGRATE;
            membrane_potential <= 8'sd0;
            spike              <= 1'b0;
            spike_count        <= 16'd0;
        end else begin
            state              <= state_nxt;
            membrane_potential <= v_nxt;
            spike              <= spike_nxt;
            spike_count        <= count_nxt;
        end
    end

endmodule

// File: tb/tb_lif_spike_generator.sv
// Self-checking bench for lif_spike_generator using a step-level behavioural neuron model.
// Builds with or without SPIKE_REFRACTORY_EN; the model follows the same macro.
module tb_lif_spike_generator;

`ifdef SPIKE_REFRACTORY_EN
    localparam int REFRAC_EFF = 2;
`else
    localparam int REFRAC_EFF = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic signed [7:0] input_current;
    logic              spike;
    logic signed [7:0] membrane_potential;
    logic              refractory;
    logic [15:0]       spike_count;

    int checks = 0;
    int errors = 0;

    // Reference model: potential, last spike, remaining refractory steps, spike total
    int m_v;
    bit m_spike;
    int m_rc;
    int m_cnt;

    lif_spike_generator dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .input_current      (input_current),
        .spike              (spike),
        .membrane_potential (membrane_potential),
        .refractory         (refractory),
        .spike_count        (spike_count)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] exp_vec();
        logic signed [7:0] v8;
        v8 = 8'(m_v);
        return {m_spike, (m_rc != 0), v8, 16'(m_cnt)};
    endfunction

    function automatic logic [25:0] got_vec();
        return {spike, refractory, membrane_potential, spike_count};
    endfunction

    task automatic model_reset();
        m_v = 0; m_spike = 0; m_rc = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input int cur);
        int s;
        if (!en) begin
            m_spike = 0;
        end else if (m_rc > 0) begin
            m_rc--;
            m_v = 0;
            m_spike = 0;
        end else begin
            s = m_v - (m_v >>> 3) + cur;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (s >= 64) begin
                m_spike = 1;
                m_v = 0;
                if (m_cnt < 65535) m_cnt++;
                m_rc = REFRAC_EFF;
            end else begin
                m_spike = 0;
                m_v = s;
            end
        end
    endtask

    task automatic step(input bit en, input logic signed [7:0] cur);
        enable = en;
        input_current = cur;
        @(posedge clk);
        #1;
        model_step(en, int'(cur));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        input_current = 8'sd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 8'sd30);
        step(1, 8'sd30);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (got_vec() !== 26'd0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0", got_vec());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        logic signed [7:0] v_req [4] = '{8'sd20, 8'sd38, 8'sd54, 8'sd0};
        bit                s_req [4] = '{0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'sd20);
            checks++;
            if (membrane_potential !== v_req[i] || spike !== s_req[i] || got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ramp step%0d: got v=%0d spike=%b vec=%h expected v=%0d spike=%b vec=%h",
                         i, membrane_potential, spike, got_vec(), v_req[i], s_req[i], exp_vec());
            end
        end
        step(0, 8'sd0);
        checks++;
        if (spike !== 1'b0 || spike_count !== 16'd1) begin
            errors++;
            $display("FAIL ramp_pulse: got spike=%b count=%0d expected spike=0 count=1", spike, spike_count);
        end
    endtask

    task automatic test_refractory();
`ifdef SPIKE_REFRACTORY_EN
        bit s_req [4] = '{1, 0, 0, 1};
`else
        bit s_req [4] = '{1, 1, 1, 1};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'sd100);
            checks++;
            if (spike !== s_req[i] || membrane_potential !== 8'sd0 || got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL refrac step%0d: got %h expected %h (spike req %b)",
                         i, got_vec(), exp_vec(), s_req[i]);
            end
        end
    endtask

    task automatic test_negative_sat();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, -8'sd128);
            checks++;
            if (membrane_potential !== -8'sd128 || spike !== 1'b0 || got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL neg_sat step%0d: got v=%0d vec=%h expected v=-128 vec=%h",
                         i, membrane_potential, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 8'sd20);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'sd127);
            checks++;
            if (membrane_potential !== 8'sd54 || spike !== 1'b0 || got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold cyc%0d: got v=%0d spike=%b expected v=54 spike=0",
                         i, membrane_potential, spike);
            end
        end
    endtask

    task automatic test_reset_in_refractory();
        do_reset();
        step(1, 8'sd100);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (refractory !== 1'b0 || got_vec() !== 26'd0) begin
            errors++;
            $display("FAIL reset_refrac: got %h expected 0", got_vec());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 8'sd30);
        checks++;
        if (membrane_potential !== 8'sd30 || refractory !== 1'b0 || got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_refrac_step: got v=%0d vec=%h expected v=30 vec=%h",
                     membrane_potential, got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random step%0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        input_current = 8'sd0;
        model_reset();
        #12;
        test_reset();
        test_ramp();
        test_refractory();
        test_negative_sat();
        test_hold();
        test_reset_in_refractory();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
